// File: rtl/dac_ctrl_axil_regs.sv
// AXI4-Lite register block driving a DAC sample register.
// A programmable divider periodically loads DATA into the DAC output.
module dac_ctrl_axil_regs #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [15:0]                     dac_sample,
  output logic                            dac_update
);

  localparam int unsigned DW = C_S_AXI_DATA_WIDTH;
  localparam int unsigned SW = DW / 8;
  localparam int unsigned CW = 16;

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_DATA   = 2'd1;
  localparam logic [1:0] A_DIV    = 2'd2;
  localparam logic [1:0] A_STATUS = 2'd3;

  logic          r_aw_held;
  logic [1:0]    r_aw_addr;
  logic          r_w_held;
  logic [DW-1:0] r_wdata;
  logic [SW-1:0] r_wstrb;
  logic          r_bvalid;
  logic          r_rvalid;
  logic [DW-1:0] r_rdata;
  logic [DW-1:0] r_ctrl;
  logic [DW-1:0] r_data;
  logic [DW-1:0] r_div;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_upd_cnt;
  logic [CW-1:0] r_sample;
  logic          r_update;

  logic          w_commit;
  logic          w_ar_hs;
  logic [DW-1:0] w_status;
  logic [DW-1:0] w_rdata;
  logic          w_unused;

  function automatic logic [DW-1:0] f_merge(input logic [DW-1:0] old_v,
                                            input logic [DW-1:0] new_v,
                                            input logic [SW-1:0] strb);
    logic [DW-1:0] v;
    v = old_v;
    for (int i = 0; i < int'(SW); i++) begin
      if (strb[i]) v[8*i +: 8] = new_v[8*i +: 8];
    end
    return v;
  endfunction

  // Ready outputs are forced low for as long as reset is asserted.
  assign S_AXI_AWREADY = ~ARESET & ~r_aw_held;
  assign S_AXI_WREADY  = ~ARESET & ~r_w_held;
  assign S_AXI_ARREADY = ~ARESET & ~r_rvalid;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_RRESP   = 2'b00;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign dac_sample    = r_sample;
  assign dac_update    = r_update;

  assign w_commit = r_aw_held & r_w_held & ~r_bvalid;
  assign w_ar_hs  = S_AXI_ARVALID & S_AXI_ARREADY;
  assign w_status = {r_upd_cnt, {(DW-CW-1){1'b0}}, r_ctrl[0]};
  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

  always_comb begin
    w_rdata = '0;
    case (S_AXI_ARADDR[3:2])
      A_CTRL:   w_rdata = r_ctrl;
      A_DATA:   w_rdata = r_data;
      A_DIV:    w_rdata = r_div;
      A_STATUS: w_rdata = w_status;
      default:  w_rdata = '0;
    endcase
  end

  // Write path: independent AW/W holds, commit when both present and B is free.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_aw_held <= 1'b0;
      r_aw_addr <= '0;
      r_w_held  <= 1'b0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bvalid  <= 1'b0;
      r_ctrl    <= '0;
      r_data    <= '0;
      r_div     <= '0;
    end else begin
      if (S_AXI_AWVALID && S_AXI_AWREADY) begin
        r_aw_held <= 1'b1;
        r_aw_addr <= S_AXI_AWADDR[3:2];
      end
      if (S_AXI_WVALID && S_AXI_WREADY) begin
        r_w_held <= 1'b1;
        r_wdata  <= S_AXI_WDATA;
        r_wstrb  <= S_AXI_WSTRB;
      end
      if (w_commit) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bvalid  <= 1'b1;
        case (r_aw_addr)
          A_CTRL:  r_ctrl <= f_merge(r_ctrl, r_wdata, r_wstrb);
          A_DATA:  r_data <= f_merge(r_data, r_wdata, r_wstrb);
          A_DIV:   r_div  <= f_merge(r_div, r_wdata, r_wstrb);
          default: ;
        endcase
      end else if (r_bvalid && S_AXI_BREADY) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  // Read path: data captured from pre-commit register contents.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rdata;
    end else if (r_rvalid && S_AXI_RREADY) begin
      r_rvalid <= 1'b0;
    end
  end

  // Divider: >= compare so a lowered DIV takes effect immediately.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_cnt     <= '0;
      r_upd_cnt <= '0;
      r_sample  <= '0;
      r_update  <= 1'b0;
    end else if (r_ctrl[0]) begin
      if (r_cnt >= r_div[CW-1:0]) begin
        r_cnt     <= '0;
        r_update  <= 1'b1;
        r_sample  <= r_data[CW-1:0];
        r_upd_cnt <= r_upd_cnt + CW'(1);
      end else begin
        r_cnt    <= r_cnt + CW'(1);
        r_update <= 1'b0;
      end
    end else begin
      r_cnt    <= '0;
      r_update <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dac_ctrl_axil_regs.sv
// Directed testbench for dac_ctrl_axil_regs: register access, handshakes,
// DAC divider timing and reset behaviour.
module tb_dac_ctrl_axil_regs;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [3:0]  S_AXI_AWADDR;
  logic [2:0]  S_AXI_AWPROT;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic [3:0]  S_AXI_ARADDR;
  logic [2:0]  S_AXI_ARPROT;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;
  logic [15:0] dac_sample;
  logic        dac_update;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int bv_rise = 0;
  logic bv_d = 1'b0;
  int upd_q[$];

  dac_ctrl_axil_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .dac_sample(dac_sample), .dac_update(dac_update)
  );

  always #5 ACLK = ~ACLK;

  // Timestamp log of update pulses and BVALID rises, in negedge cycles.
  always @(negedge ACLK) begin
    cyc <= cyc + 1;
    if (dac_update) upd_q.push_back(cyc);
    bv_d <= S_AXI_BVALID;
    if (S_AXI_BVALID && !bv_d) bv_rise <= cyc;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output bit ok);
    logic aw_hs, w_hs;
    bit got;
    ok = 1'b1; got = 1'b0; resp = 2'b11;
    S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    for (int n = 0; n < 50 && (S_AXI_AWVALID || S_AXI_WVALID); n++) begin
      @(negedge ACLK);
      aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
      w_hs  = S_AXI_WVALID && S_AXI_WREADY;
      @(posedge ACLK); #1;
      if (aw_hs) S_AXI_AWVALID = 1'b0;
      if (w_hs)  S_AXI_WVALID  = 1'b0;
    end
    if (S_AXI_AWVALID || S_AXI_WVALID) ok = 1'b0;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    S_AXI_BREADY = 1'b1;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge ACLK);
      if (S_AXI_BVALID) begin resp = S_AXI_BRESP; got = 1'b1; end
      @(posedge ACLK); #1;
    end
    S_AXI_BREADY = 1'b0;
    if (!got) ok = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d, output logic [1:0] resp,
                          output bit ok);
    logic ar_hs;
    bit got;
    ok = 1'b1; got = 1'b0; d = 32'hDEAD_BEEF; resp = 2'b11;
    S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1;
    for (int n = 0; n < 50 && S_AXI_ARVALID; n++) begin
      @(negedge ACLK);
      ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;
      @(posedge ACLK); #1;
      if (ar_hs) S_AXI_ARVALID = 1'b0;
    end
    if (S_AXI_ARVALID) ok = 1'b0;
    S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY = 1'b1;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge ACLK);
      if (S_AXI_RVALID) begin d = S_AXI_RDATA; resp = S_AXI_RRESP; got = 1'b1; end
      @(posedge ACLK); #1;
    end
    S_AXI_RREADY = 1'b0;
    if (!got) ok = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic [1:0] r; bit ok;
    ARESET = 1'b1;
    S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
    S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    checks++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID, dac_update} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl_outputs: got %b expected 000000",
               {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID, dac_update});
    end
    checks++;
    if (dac_sample !== 16'h0000) begin
      failures++; $display("FAIL reset_dac_sample: got %h expected 0000", dac_sample);
    end
    @(posedge ACLK); #1; ARESET = 1'b0;
    @(negedge ACLK);
    checks++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b111) begin
      failures++; $display("FAIL reset_release_ready: got %b expected 111",
                           {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY});
    end
    @(posedge ACLK); #1;
    axi_read(4'h0, d, r, ok);
    checks++;
    if (!ok || d !== 32'h0 || r !== 2'b00) begin
      failures++; $display("FAIL reset_ctrl_read: got %h resp %b ok %0d expected 00000000", d, r, ok);
    end
  endtask

  task automatic test_strobe();
    logic [31:0] d; logic [1:0] r; bit ok;
    axi_write(4'h4, 32'hAABB_CCDD, 4'b0101, r, ok);
    checks++;
    if (!ok || r !== 2'b00) begin
      failures++; $display("FAIL strobe_bresp: got %b ok %0d expected 00", r, ok);
    end
    axi_read(4'h4, d, r, ok);
    checks++;
    if (!ok || d !== 32'h00BB_00DD) begin
      failures++; $display("FAIL strobe_readback: got %h expected 00bb00dd", d);
    end
  endtask

  task automatic test_status_ro();
    logic [31:0] d; logic [1:0] r; bit ok;
    axi_write(4'hC, 32'hFFFF_FFFF, 4'hF, r, ok);
    checks++;
    if (!ok || r !== 2'b00) begin
      failures++; $display("FAIL status_write_bresp: got %b ok %0d expected 00", r, ok);
    end
    axi_read(4'hC, d, r, ok);
    checks++;
    if (!ok || d !== 32'h0) begin
      failures++; $display("FAIL status_unchanged: got %h expected 00000000", d);
    end
    axi_read(4'h4, d, r, ok);
    checks++;
    if (!ok || d !== 32'h00BB_00DD) begin
      failures++; $display("FAIL status_write_side_effect: got %h expected 00bb00dd", d);
    end
  endtask

  task automatic test_w_before_aw();
    logic [31:0] d; logic [1:0] r; bit ok;
    logic w_hs, aw_rdy;
    bit got;
    int good, again;
    S_AXI_WDATA = 32'h0000_0055; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    @(negedge ACLK);
    w_hs = S_AXI_WVALID && S_AXI_WREADY;
    @(posedge ACLK); #1;
    if (w_hs) S_AXI_WVALID = 1'b0;
    repeat (2) begin @(negedge ACLK); @(posedge ACLK); #1; end
    S_AXI_WVALID = 1'b0;
    @(negedge ACLK);
    checks++;
    if (S_AXI_WREADY !== 1'b0 || S_AXI_BVALID !== 1'b0 || S_AXI_AWREADY !== 1'b1) begin
      failures++; $display("FAIL w_held_no_commit: wready %b bvalid %b awready %b expected 0 0 1",
                           S_AXI_WREADY, S_AXI_BVALID, S_AXI_AWREADY);
    end
    @(posedge ACLK); #1;
    S_AXI_AWADDR = 4'h8; S_AXI_AWVALID = 1'b1;
    @(negedge ACLK);
    aw_rdy = S_AXI_AWREADY;
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 10 && !got; n++) begin
      @(negedge ACLK);
      if (S_AXI_BVALID) got = 1'b1;
    end
    checks++;
    if (!got || aw_rdy !== 1'b1) begin
      failures++; $display("FAIL late_aw_bvalid: bvalid_seen %0d awready %b expected 1 1", got, aw_rdy);
    end
    good = 0;
    repeat (5) begin
      @(negedge ACLK);
      if (S_AXI_BVALID === 1'b1 && S_AXI_BRESP === 2'b00) good++;
    end
    checks++;
    if (good != 5) begin
      failures++; $display("FAIL bvalid_hold: got %0d stable cycles expected 5", good);
    end
    @(posedge ACLK); #1; S_AXI_BREADY = 1'b1;
    @(posedge ACLK); #1; S_AXI_BREADY = 1'b0;
    again = 0;
    repeat (6) begin
      @(negedge ACLK);
      if (S_AXI_BVALID !== 1'b0) again++;
    end
    checks++;
    if (again != 0) begin
      failures++; $display("FAIL single_commit: got %0d bvalid cycles after handshake expected 0", again);
    end
    @(posedge ACLK); #1;
    axi_read(4'h8, d, r, ok);
    checks++;
    if (!ok || d !== 32'h0000_0055) begin
      failures++; $display("FAIL late_aw_readback: got %h expected 00000055", d);
    end
  endtask

  task automatic test_rw_collision();
    logic [31:0] d; logic [1:0] r; bit ok;
    S_AXI_AWADDR = 4'h4; S_AXI_WDATA = 32'h0000_1234; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    @(negedge ACLK);
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    S_AXI_ARADDR = 4'h4; S_AXI_ARVALID = 1'b1;
    @(negedge ACLK);
    @(posedge ACLK); #1;
    S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b1; S_AXI_BREADY = 1'b1;
    @(negedge ACLK);
    checks++;
    if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== 32'h00BB_00DD || S_AXI_BVALID !== 1'b1) begin
      failures++; $display("FAIL collision_old_value: rvalid %b rdata %h bvalid %b expected 1 00bb00dd 1",
                           S_AXI_RVALID, S_AXI_RDATA, S_AXI_BVALID);
    end
    @(posedge ACLK); #1;
    S_AXI_RREADY = 1'b0; S_AXI_BREADY = 1'b0;
    @(negedge ACLK);
    @(posedge ACLK); #1;
    axi_read(4'h4, d, r, ok);
    checks++;
    if (!ok || d !== 32'h0000_1234) begin
      failures++; $display("FAIL collision_new_value: got %h expected 00001234", d);
    end
  endtask

  task automatic test_dac_period();
    logic [31:0] d, s1, s2; logic [1:0] r; bit ok;
    axi_write(4'h8, 32'h0000_0003, 4'hF, r, ok);
    upd_q.delete();
    axi_write(4'h0, 32'h0000_0001, 4'hF, r, ok);
    repeat (20) @(posedge ACLK);
    #1;
    checks++;
    if (upd_q.size() < 3) begin
      failures++; $display("FAIL period_pulse_count: got %0d expected >=3", upd_q.size());
    end else begin
      checks++;
      if (upd_q[0] - bv_rise != 4) begin
        failures++; $display("FAIL first_update_latency: got %0d expected 4", upd_q[0] - bv_rise);
      end
      checks++;
      if (upd_q[1] - upd_q[0] != 4 || upd_q[2] - upd_q[1] != 4) begin
        failures++; $display("FAIL update_period: got %0d,%0d expected 4,4",
                             upd_q[1] - upd_q[0], upd_q[2] - upd_q[1]);
      end
    end
    checks++;
    if (dac_sample !== 16'h1234) begin
      failures++; $display("FAIL dac_sample_value: got %h expected 1234", dac_sample);
    end
    axi_read(4'hC, s1, r, ok);
    repeat (10) @(posedge ACLK);
    #1;
    axi_read(4'hC, s2, r, ok);
    checks++;
    if (s1[15:0] !== 16'h0001 || s1[31:24] !== 8'h00 || s1[31:16] == 16'h0) begin
      failures++; $display("FAIL status_format: got %h expected 00NN0001 with NN>0", s1);
    end
    checks++;
    if (s2[31:16] <= s1[31:16] || s2[15:0] !== 16'h0001) begin
      failures++; $display("FAIL status_count_up: got %h after %h expected larger count", s2, s1);
    end
    d = s2;
  endtask

  task automatic test_div_zero();
    logic [1:0] r; bit ok;
    axi_write(4'h8, 32'h0, 4'hF, r, ok);
    repeat (2) @(posedge ACLK);
    #1;
    upd_q.delete();
    repeat (10) @(posedge ACLK);
    #1;
    checks++;
    if (upd_q.size() != 10) begin
      failures++; $display("FAIL div_zero_every_cycle: got %0d pulses expected 10", upd_q.size());
    end
  endtask

  task automatic test_disable();
    logic [31:0] s1, s2; logic [1:0] r; bit ok;
    axi_write(4'h0, 32'h0, 4'hF, r, ok);
    repeat (2) @(posedge ACLK);
    #1;
    upd_q.delete();
    axi_read(4'hC, s1, r, ok);
    repeat (20) @(posedge ACLK);
    #1;
    axi_read(4'hC, s2, r, ok);
    checks++;
    if (upd_q.size() != 0 || dac_sample !== 16'h1234) begin
      failures++; $display("FAIL disable_hold: got %0d pulses sample %h expected 0 1234",
                           upd_q.size(), dac_sample);
    end
    checks++;
    if (s1[0] !== 1'b0 || s2 !== s1) begin
      failures++; $display("FAIL disable_status: got %h then %h expected equal with bit0=0", s1, s2);
    end
  endtask

  task automatic test_div_lower();
    logic [1:0] r; bit ok;
    axi_write(4'h8, 32'h0000_0100, 4'hF, r, ok);
    axi_write(4'h0, 32'h0000_0001, 4'hF, r, ok);
    repeat (120) @(posedge ACLK);
    #1;
    upd_q.delete();
    axi_write(4'h8, 32'h0000_0010, 4'hF, r, ok);
    repeat (40) @(posedge ACLK);
    #1;
    checks++;
    if (upd_q.size() < 3) begin
      failures++; $display("FAIL div_lower_pulses: got %0d expected >=3", upd_q.size());
    end else begin
      checks++;
      if (upd_q[0] - bv_rise != 1) begin
        failures++; $display("FAIL div_lower_immediate: got %0d expected 1", upd_q[0] - bv_rise);
      end
      checks++;
      if (upd_q[1] - upd_q[0] != 17 || upd_q[2] - upd_q[1] != 17) begin
        failures++; $display("FAIL div_lower_period: got %0d,%0d expected 17,17",
                             upd_q[1] - upd_q[0], upd_q[2] - upd_q[1]);
      end
    end
  endtask

  task automatic test_reset_pending();
    logic [31:0] d; logic [1:0] r; bit ok;
    S_AXI_ARADDR = 4'h0; S_AXI_ARVALID = 1'b1;
    @(negedge ACLK);
    @(posedge ACLK); #1;
    S_AXI_ARVALID = 1'b0;
    @(negedge ACLK);
    checks++;
    if (S_AXI_RVALID !== 1'b1) begin
      failures++; $display("FAIL pending_rvalid: got %b expected 1", S_AXI_RVALID);
    end
    @(posedge ACLK); #1; ARESET = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    checks++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID, dac_update} !== 6'b0 ||
        dac_sample !== 16'h0 || S_AXI_RDATA !== 32'h0) begin
      failures++; $display("FAIL reset_pending_outputs: got %b sample %h rdata %h expected all 0",
                           {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID, dac_update},
                           dac_sample, S_AXI_RDATA);
    end
    @(posedge ACLK); #1; ARESET = 1'b0;
    @(negedge ACLK);
    checks++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_RVALID} !== 4'b1110) begin
      failures++; $display("FAIL reset_pending_release: got %b expected 1110",
                           {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_RVALID});
    end
    @(posedge ACLK); #1;
    axi_read(4'h0, d, r, ok);
    checks++;
    if (!ok || d !== 32'h0) begin
      failures++; $display("FAIL reset_pending_ctrl: got %h expected 00000000", d);
    end
    axi_read(4'hC, d, r, ok);
    checks++;
    if (!ok || d !== 32'h0) begin
      failures++; $display("FAIL reset_pending_status: got %h expected 00000000", d);
    end
  endtask

  initial begin
    test_reset();
    test_strobe();
    test_status_ro();
    test_w_before_aw();
    test_rw_collision();
    test_dac_period();
    test_div_zero();
    test_disable();
    test_div_lower();
    test_reset_pending();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
